ozdemir_mem: RTL and testbench
==============================

OZDEMIR_MEM -- requirements
Module: ozdemir_mem

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit words in the unified memory (power of two, 16..4096).
REQ-002 SHALL have parameter RESET_CLEAR, default 1, meaning all words clear to 0 on reset when 1 and keep their contents when 0.
REQ-003 SHALL use one clock and an asynchronous, active-high reset; all state updates on the rising edge of clk_i.
REQ-004 clk_i  in  1  system clock.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 pc_i  in  32  instruction fetch byte address.
REQ-007 inst_o  out  32  fetched instruction word, byte-reversed.
REQ-008 data_mem_we_i  in  1  data write enable.
REQ-009 data_mem_addr_i  in  32  data byte address.
REQ-010 data_mem_wdata_i  in  32  data write word.
REQ-011 data_mem_rdata_o  out  32  data read word, registered.
REQ-012 load_start_i  in  1  one-cycle pulse that restarts the loader at load_base_i.
REQ-013 load_base_i  in  32  loader start byte address; bits [1:0] ignored.
REQ-014 load_valid_i  in  1  load_byte_i is valid.
REQ-015 load_byte_i  in  8  loader data byte.
REQ-016 load_ready_o  out  1  loader accepts a byte this cycle.
REQ-017 err_o  out  1  sticky flag for an access outside memory or a misaligned access.
REQ-018 wr_count_o  out  16  count of committed data-port writes, saturating.

Function
REQ-019 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; an address SHALL be out of range when addr[31:2] >= DEPTH_WORDS.
REQ-020 inst_o SHALL be combinational: the stored word W at pc_i, output as {W[7:0],W[15:8],W[23:16],W[31:24]}; out of range SHALL give 32'h0000_0013 byte-reversed.
REQ-021 data_mem_rdata_o SHALL update each cycle to mem[data_mem_addr_i], read before write; out of range SHALL read 0.
REQ-022 A write with data_mem_we_i=1, in range and addr[1:0]=00, SHALL store data_mem_wdata_i at the next edge and increment wr_count_o, which saturates at 16'hFFFF.
REQ-023 A write with data_mem_we_i=1 that is out of range or has addr[1:0]!=00 SHALL be dropped and SHALL set err_o.
REQ-024 A data read (we=0) out of range SHALL set err_o.
REQ-025 A fetch with pc_i[1:0]!=00 or pc_i out of range SHALL set err_o at the next edge.
REQ-026 err_o SHALL clear only on reset.
REQ-027 The loader FSM SHALL have two states: IDLE and FILL.
REQ-028 load_start_i SHALL take the loader to FILL, set ptr=load_base_i[31:2], set byte_cnt=0 and discard any partial word; load_start_i SHALL have priority over a byte offered in the same cycle.
REQ-029 In FILL, load_ready_o SHALL be 1 unless data_mem_we_i=1 in that cycle (the core write wins; the loader stalls with no byte loss).
REQ-030 In IDLE, load_ready_o SHALL be 0.
REQ-031 An accepted byte (valid & ready) SHALL go into the assembly register at lane byte_cnt (byte 0 in bits [7:0]), and byte_cnt SHALL increment.
REQ-032 On the 4th byte, the assembled word SHALL be written to mem[ptr]; ptr SHALL increment and byte_cnt SHALL return to 0.
REQ-033 If ptr wraps past DEPTH_WORDS-1, the loader SHALL return to IDLE and set err_o.
REQ-034 Loader commits SHALL NOT increment wr_count_o.
REQ-035 When a loader commit and a core write target the same word in one cycle, this cannot occur by REQ-029; the core write SHALL be the only write in that cycle.

Reset
REQ-036 On rst_i=1 the block SHALL, asynchronously: set data_mem_rdata_o=0, err_o=0, wr_count_o=0, loader=IDLE, load_ready_o=0, byte_cnt=0, ptr=0 and assembly register=0.
REQ-037 With RESET_CLEAR=1, reset SHALL also clear all memory words to 0.
REQ-038 Reset during a partial loader word SHALL discard the partial bytes, and no memory write SHALL occur.

Verification
REQ-039 Load and fetch: load_start with base 0, then bytes 13,05,A0,00 -> mem[0]=32'h00A00513 and inst_o at pc_i=0 is 32'h1305A000.
REQ-040 Write then read: we=1 at addr 0x10 with wdata 0xDEADBEEF, then we=0 at 0x10 -> the next-cycle rdata is 0xDEADBEEF and wr_count_o=1.
REQ-041 Same-cycle read/write: we=1 at 0x20 with 0x1 while holding addr 0x20 -> the rdata at that edge is the old value and the following cycle gives 0x1.
REQ-042 Error cases: we=1 at addr 0x22 -> memory is unchanged and err_o=1 sticky; with DEPTH=256, a read at 0x400 -> rdata=0 and err_o=1.
REQ-043 Stall: loader in FILL, load_valid_i=1 held, and a core write in the same cycle -> load_ready_o=0, the byte is accepted next cycle, and the word commits correctly.
REQ-044 Reset mid-load: 2 bytes accepted, then a rst_i pulse -> loader is IDLE, byte_cnt=0 and the target word is unchanged, or 0 when RESET_CLEAR=1.

Source files
------------

// File: rtl/ozdemir_mem.sv
// Unified instruction/data word memory with a byte-stream loader.
// Fetch is combinational and byte-reversed; the data port reads registered, read-before-write.
module ozdemir_mem #(
  parameter int DEPTH_WORDS = 256,
  parameter bit RESET_CLEAR = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  output logic [31:0] inst_o,
  input  logic        data_mem_we_i,
  input  logic [31:0] data_mem_addr_i,
  input  logic [31:0] data_mem_wdata_i,
  output logic [31:0] data_mem_rdata_o,
  input  logic        load_start_i,
  input  logic [31:0] load_base_i,
  input  logic        load_valid_i,
  input  logic [7:0]  load_byte_i,
  output logic        load_ready_o,
  output logic        err_o,
  output logic [15:0] wr_count_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [29:0]   DEPTH_W  = 30'(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);
  localparam logic [31:0]   NOP_WORD = 32'h0000_0013;

  typedef enum logic [0:0] {
    LD_IDLE = 1'b0,
    LD_FILL = 1'b1
  } ld_state_t;

  function automatic logic [31:0] byte_rev(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic addr_in_range(input logic [31:0] a);
    return (a[31:2] < DEPTH_W);
  endfunction

  logic [31:0]   mem_r [DEPTH_WORDS];
  ld_state_t     ld_state_r;
  ld_state_t     ld_state_nxt_s;
  logic [AW-1:0] ptr_r;
  logic [1:0]    byte_cnt_r;
  logic [31:0]   asm_r;
  logic [31:0]   rdata_r;
  logic          err_r;
  logic [15:0]   wr_count_r;

  logic [AW-1:0] data_idx_s;
  logic [AW-1:0] pc_idx_s;
  logic          data_in_range_s;
  logic          pc_in_range_s;
  logic          core_wr_s;
  logic          core_bad_wr_s;
  logic          rd_err_s;
  logic          fetch_err_s;
  logic          ld_accept_s;
  logic          ld_commit_s;
  logic          ld_wrap_s;
  logic [31:0]   ld_word_s;
  logic          mem_we_s;
  logic [AW-1:0] mem_widx_s;
  logic [31:0]   mem_wdata_s;
  logic          unused_s;

  assign unused_s = ^{load_base_i[1:0], load_base_i[31:AW+2]};

  assign data_idx_s      = data_mem_addr_i[AW+1:2];
  assign pc_idx_s        = pc_i[AW+1:2];
  assign data_in_range_s = addr_in_range(data_mem_addr_i);
  assign pc_in_range_s   = addr_in_range(pc_i);

  assign core_wr_s     = data_mem_we_i & data_in_range_s & (data_mem_addr_i[1:0] == 2'b00);
  assign core_bad_wr_s = data_mem_we_i & ~core_wr_s;
  assign rd_err_s      = ~data_mem_we_i & ~data_in_range_s;
  assign fetch_err_s   = (pc_i[1:0] != 2'b00) | ~pc_in_range_s;

  // A byte offered alongside load_start_i is discarded by the restart.
  assign ld_accept_s = load_valid_i & load_ready_o & ~load_start_i;
  assign ld_commit_s = ld_accept_s & (byte_cnt_r == 2'd3);
  assign ld_wrap_s   = ld_commit_s & (ptr_r == LAST_IDX);
  assign ld_word_s   = {load_byte_i, asm_r[23:0]};

  assign inst_o           = pc_in_range_s ? byte_rev(mem_r[pc_idx_s]) : byte_rev(NOP_WORD);
  assign data_mem_rdata_o = rdata_r;
  assign err_o            = err_r;
  assign wr_count_o       = wr_count_r;

  // Select the single memory write of this cycle; the core port wins.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_widx_s  = '0;
    mem_wdata_s = 32'h0000_0000;
    if (core_wr_s) begin
      mem_we_s    = 1'b1;
      mem_widx_s  = data_idx_s;
      mem_wdata_s = data_mem_wdata_i;
    end else if (ld_commit_s) begin
      mem_we_s    = 1'b1;
      mem_widx_s  = ptr_r;
      mem_wdata_s = ld_word_s;
    end else begin
      mem_we_s    = 1'b0;
      mem_widx_s  = '0;
      mem_wdata_s = 32'h0000_0000;
    end
  end

  if (RESET_CLEAR == 1'b1) begin : g_mem_clr
    // Memory array with reset clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < DEPTH_WORDS; i++) begin
          mem_r[i] <= 32'h0000_0000;
        end
      end else if (mem_we_s) begin
        mem_r[mem_widx_s] <= mem_wdata_s;
      end
    end
  end else begin : g_mem_keep
    // Memory array that keeps its contents through reset.
    always_ff @(posedge clk_i) begin
      if (mem_we_s && !rst_i) begin
        mem_r[mem_widx_s] <= mem_wdata_s;
      end
    end
  end

  // Registered data read, sampled before this edge's write lands.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_r <= 32'h0000_0000;
    end else if (data_in_range_s) begin
      rdata_r <= mem_r[data_idx_s];
    end else begin
      rdata_r <= 32'h0000_0000;
    end
  end

  // Sticky access-error flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_r <= 1'b0;
    end else if (core_bad_wr_s || rd_err_s || fetch_err_s || ld_wrap_s) begin
      err_r <= 1'b1;
    end
  end

  // Saturating count of committed core writes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_count_r <= 16'h0000;
    end else if (core_wr_s && (wr_count_r != 16'hFFFF)) begin
      wr_count_r <= wr_count_r + 16'h0001;
    end
  end

  // Loader state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ld_state_r <= LD_IDLE;
    end else begin
      ld_state_r <= ld_state_nxt_s;
    end
  end

  // Loader next-state logic.
  always_comb begin
    ld_state_nxt_s = ld_state_r;
    case (ld_state_r)
      LD_IDLE: begin
        if (load_start_i) begin
          ld_state_nxt_s = LD_FILL;
        end else begin
          ld_state_nxt_s = LD_IDLE;
        end
      end
      LD_FILL: begin
        if (load_start_i) begin
          ld_state_nxt_s = LD_FILL;
        end else if (ld_wrap_s) begin
          ld_state_nxt_s = LD_IDLE;
        end else begin
          ld_state_nxt_s = LD_FILL;
        end
      end
      default: ld_state_nxt_s = LD_IDLE;
    endcase
  end

  // Loader output: stall the byte stream while the core is writing.
  always_comb begin
    load_ready_o = 1'b0;
    case (ld_state_r)
      LD_IDLE: load_ready_o = 1'b0;
      LD_FILL: load_ready_o = ~data_mem_we_i;
      default: load_ready_o = 1'b0;
    endcase
  end

  // Loader pointer, byte lane counter and word assembly.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_r      <= '0;
      byte_cnt_r <= 2'd0;
      asm_r      <= 32'h0000_0000;
    end else if (load_start_i) begin
      ptr_r      <= load_base_i[AW+1:2];
      byte_cnt_r <= 2'd0;
      asm_r      <= 32'h0000_0000;
    end else if (ld_commit_s) begin
      ptr_r      <= ptr_r + AW'(1);
      byte_cnt_r <= 2'd0;
      asm_r      <= 32'h0000_0000;
    end else if (ld_accept_s) begin
      asm_r[{byte_cnt_r, 3'b000} +: 8] <= load_byte_i;
      byte_cnt_r <= byte_cnt_r + 2'd1;
    end
  end

endmodule

// File: tb/tb_ozdemir_mem.sv
// Bench for ozdemir_mem: directed vector table, hand-written loader sequences,
// and a randomized run against a word-array/byte-queue reference model.
module tb_ozdemir_mem;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_i;
  logic [31:0] inst_o;
  logic        data_mem_we_i;
  logic [31:0] data_mem_addr_i;
  logic [31:0] data_mem_wdata_i;
  logic [31:0] data_mem_rdata_o;
  logic        load_start_i;
  logic [31:0] load_base_i;
  logic        load_valid_i;
  logic [7:0]  load_byte_i;
  logic        load_ready_o;
  logic        err_o;
  logic [15:0] wr_count_o;

  int n_pass  = 0;
  int n_total = 0;

  ozdemir_mem dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .pc_i             (pc_i),
    .inst_o           (inst_o),
    .data_mem_we_i    (data_mem_we_i),
    .data_mem_addr_i  (data_mem_addr_i),
    .data_mem_wdata_i (data_mem_wdata_i),
    .data_mem_rdata_o (data_mem_rdata_o),
    .load_start_i     (load_start_i),
    .load_base_i      (load_base_i),
    .load_valid_i     (load_valid_i),
    .load_byte_i      (load_byte_i),
    .load_ready_o     (load_ready_o),
    .err_o            (err_o),
    .wr_count_o       (wr_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] exp_inst;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [7];

  // reference model state
  logic [31:0] m_mem [256];
  logic [7:0]  m_q [$];
  bit          m_fill;
  int          m_ptr;
  bit          m_err;
  int          m_cnt;

  function automatic logic [31:0] rev(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] pc, input logic st, input logic [31:0] base,
                       input logic vld, input logic [7:0] b);
    data_mem_we_i    = we;
    data_mem_addr_i  = addr;
    data_mem_wdata_i = wdata;
    pc_i             = pc;
    load_start_i     = st;
    load_base_i      = base;
    load_valid_i     = vld;
    load_byte_i      = b;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 8'h00);
    #1;
    chk("rst_rdata", data_mem_rdata_o, 32'h0);
    chk("rst_err", {31'h0, err_o}, 32'h0);
    chk("rst_cnt", {16'h0, wr_count_o}, 32'h0);
    chk("rst_ready", {31'h0, load_ready_o}, 32'h0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic ld_start(input logic [31:0] base);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, base, 1'b0, 8'h00);
    tick();
  endtask

  task automatic ld_byte(input logic [7:0] b);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, b);
    chk("ld_ready", {31'h0, load_ready_o}, 32'h1);
    tick();
  endtask

  task automatic rd(input string nm, input logic [31:0] addr, input logic [31:0] exp);
    drive(1'b0, addr, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 8'h00);
    tick();
    chk(nm, data_mem_rdata_o, exp);
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h10,  32'hDEADBEEF, 32'h0,   32'h0,        32'h0,        1'b0, 16'd1};
    vecs[1] = '{1'b0, 32'h10,  32'h0,        32'h10,  32'hEFBEADDE, 32'hDEADBEEF, 1'b0, 16'd1};
    vecs[2] = '{1'b1, 32'h20,  32'h1,        32'h0,   32'h0,        32'h0,        1'b0, 16'd2};
    vecs[3] = '{1'b0, 32'h20,  32'h0,        32'h20,  32'h01000000, 32'h1,        1'b0, 16'd2};
    vecs[4] = '{1'b1, 32'h22,  32'hFFFFFFFF, 32'h0,   32'h0,        32'h1,        1'b1, 16'd2};
    vecs[5] = '{1'b0, 32'h20,  32'h0,        32'h0,   32'h0,        32'h1,        1'b1, 16'd2};
    vecs[6] = '{1'b0, 32'h400, 32'h0,        32'h400, 32'h13000000, 32'h0,        1'b1, 16'd2};

    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].pc, 1'b0, 32'h0, 1'b0, 8'h00);
      chk($sformatf("vec%0d_inst", i), inst_o, vecs[i].exp_inst);
      tick();
      chk($sformatf("vec%0d_rdata", i), data_mem_rdata_o, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), {31'h0, err_o}, {31'h0, vecs[i].exp_err});
      chk($sformatf("vec%0d_cnt", i), {16'h0, wr_count_o}, {16'h0, vecs[i].exp_cnt});
    end

    // out-of-range read alone sets err
    do_reset();
    rd("oor_rdata", 32'h400, 32'h0);
    chk("oor_err", {31'h0, err_o}, 32'h1);

    // load and fetch
    do_reset();
    ld_start(32'h0);
    ld_byte(8'h13); ld_byte(8'h05); ld_byte(8'hA0); ld_byte(8'h00);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 8'h00);
    chk("load_inst", inst_o, 32'h1305A000);
    tick();
    chk("load_rdata", data_mem_rdata_o, 32'h00A00513);
    chk("load_cnt", {16'h0, wr_count_o}, 32'h0);
    chk("load_err", {31'h0, err_o}, 32'h0);

    // stall: core write beats an offered byte
    ld_start(32'h40);
    drive(1'b1, 32'h80, 32'h5, 32'h0, 1'b0, 32'h0, 1'b1, 8'hAA);
    chk("stall_ready", {31'h0, load_ready_o}, 32'h0);
    tick();
    ld_byte(8'hAA); ld_byte(8'hBB); ld_byte(8'hCC); ld_byte(8'hDD);
    rd("stall_word", 32'h40, 32'hDDCCBBAA);
    rd("stall_core", 32'h80, 32'h5);
    chk("stall_cnt", {16'h0, wr_count_o}, 32'h1);

    // restart drops the partial word and the coincident byte
    ld_start(32'h60);
    ld_byte(8'h9A);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h60, 1'b1, 8'h55);
    tick();
    ld_byte(8'h01); ld_byte(8'h02); ld_byte(8'h03); ld_byte(8'h04);
    rd("restart_word", 32'h60, 32'h04030201);

    // wrap at the last word
    do_reset();
    ld_start(32'h3FC);
    ld_byte(8'h11); ld_byte(8'h22); ld_byte(8'h33);
    chk("wrap_err_pre", {31'h0, err_o}, 32'h0);
    ld_byte(8'h44);
    chk("wrap_err", {31'h0, err_o}, 32'h1);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 8'h99);
    chk("wrap_idle_ready", {31'h0, load_ready_o}, 32'h0);
    tick();
    rd("wrap_word", 32'h3FC, 32'h44332211);
    rd("wrap_no_w0", 32'h0, 32'h0);

    // reset mid-load
    drive(1'b1, 32'h50, 32'h77, 32'h0, 1'b0, 32'h0, 1'b0, 8'h00);
    tick();
    ld_start(32'h50);
    ld_byte(8'h01); ld_byte(8'h02);
    do_reset();
    rd("midrst_word", 32'h50, 32'h0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 8'(i + 3));
      chk("midrst_ready", {31'h0, load_ready_o}, 32'h0);
      tick();
    end
    rd("midrst_word2", 32'h50, 32'h0);

    // write counter saturation
    do_reset();
    drive(1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 8'h00);
    for (int i = 0; i < 65535; i++) begin
      @(posedge clk_i);
    end
    #1;
    chk("sat_cnt", {16'h0, wr_count_o}, 32'h0000FFFF);
    tick(); tick();
    chk("sat_hold", {16'h0, wr_count_o}, 32'h0000FFFF);

    // randomized run against the reference model
    do_reset();
    for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;
    m_q.delete();
    m_fill = 1'b0; m_ptr = 0; m_err = 1'b0; m_cnt = 0;
    for (int k = 0; k < 2000; k++) begin
      logic        r_we, r_st, r_v, in_a, in_pc;
      logic [31:0] r_a, r_wd, r_pc, r_base, e_inst, e_rdata;
      logic [7:0]  r_b;
      int          idx;
      r_we = ($urandom_range(0, 3) == 0);
      r_a  = $urandom_range(0, 255) << 2;
      if ($urandom_range(0, 40) == 0) r_a = $urandom();
      if ($urandom_range(0, 40) == 0) r_a[1:0] = 2'($urandom_range(1, 3));
      r_wd = $urandom();
      r_pc = $urandom_range(0, 255) << 2;
      if ($urandom_range(0, 60) == 0) r_pc = $urandom();
      r_st = ($urandom_range(0, 40) == 0);
      r_base = $urandom_range(0, 255) << 2;
      if ($urandom_range(0, 3) == 0) r_base = $urandom_range(250, 255) << 2;
      r_v = ($urandom_range(0, 1) == 1);
      r_b = 8'($urandom());
      drive(r_we, r_a, r_wd, r_pc, r_st, r_base, r_v, r_b);

      in_pc  = ((r_pc >> 2) < 256);
      e_inst = in_pc ? rev(m_mem[(r_pc >> 2) & 255]) : 32'h13000000;
      chk("rnd_ready", {31'h0, load_ready_o}, {31'h0, (m_fill && !r_we)});
      chk("rnd_inst", inst_o, e_inst);

      in_a    = ((r_a >> 2) < 256);
      idx     = int'((r_a >> 2) & 255);
      e_rdata = in_a ? m_mem[idx] : 32'h0;
      if (r_we) begin
        if (in_a && (r_a[1:0] == 2'b00)) begin
          m_mem[idx] = r_wd;
          if (m_cnt < 65535) m_cnt++;
        end else m_err = 1'b1;
      end else if (!in_a) m_err = 1'b1;
      if ((r_pc[1:0] != 2'b00) || !in_pc) m_err = 1'b1;
      if (r_st) begin
        m_fill = 1'b1;
        m_ptr  = int'((r_base >> 2) % 256);
        m_q.delete();
      end else if (m_fill && r_v && !r_we) begin
        m_q.push_back(r_b);
        if (m_q.size() == 4) begin
          m_mem[m_ptr] = {m_q[3], m_q[2], m_q[1], m_q[0]};
          m_q.delete();
          m_ptr++;
          if (m_ptr == 256) begin
            m_ptr = 0; m_fill = 1'b0; m_err = 1'b1;
          end
        end
      end
      tick();
      chk("rnd_rdata", data_mem_rdata_o, e_rdata);
      chk("rnd_err", {31'h0, err_o}, {31'h0, m_err});
      chk("rnd_cnt", {16'h0, wr_count_o}, m_cnt);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
